// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the miss/fill controller, its requesters, the memory
// read port and the cachemem write port. The master side is the controller.
interface cache_fill_ctrl_if #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_LINES  = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int DATA_BITS  = 64,
    parameter int TAG_BITS   = 25
);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int OFF_BITS  = $clog2(BLOCK_SIZE);
    localparam int ADDR_BITS = TAG_BITS + IDX_BITS + OFF_BITS;

    logic [NUM_REQ-1:0]                miss_valid;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] miss_addr;

    logic                 mem_req_valid;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic [DATA_BITS-1:0] mem_resp_data;

    logic                 wr_en;
    logic [IDX_BITS-1:0]  wr_idx;
    logic [TAG_BITS-1:0]  wr_tag;
    logic [DATA_BITS-1:0] wr_data;

    logic [NUM_REQ-1:0]   fill_done;

    modport master (
        input  miss_valid, miss_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output mem_req_valid, mem_req_addr,
        output wr_en, wr_idx, wr_tag, wr_data,
        output fill_done
    );

    modport slave (
        output miss_valid, miss_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  mem_req_valid, mem_req_addr,
        input  wr_en, wr_idx, wr_tag, wr_data,
        input  fill_done
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss handler and fill sequencer for the direct-mapped cachemem. Picks one
// missing requester round-robin, fetches its block from memory with a single
// outstanding request, writes the block into cachemem for one cycle and
// pulses fill_done to every requester waiting on that same block.
module cache_fill_ctrl #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_LINES  = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int DATA_BITS  = 64,
    parameter int TAG_BITS   = 25
) (
    input  logic               clock,
    input  logic               reset,
    cache_fill_ctrl_if.master  bus,
    output logic               busy
);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int OFF_BITS  = $clog2(BLOCK_SIZE);
    localparam int ADDR_BITS = TAG_BITS + IDX_BITS + OFF_BITS;
    localparam int BLK_BITS  = TAG_BITS + IDX_BITS;
    localparam int PTR_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PTR_BITS-1:0]  rr_ptr;
    logic [PTR_BITS-1:0]  grant_q;
    logic [BLK_BITS-1:0]  blk_q;
    logic [DATA_BITS-1:0] data_q;

    logic                 grant_found;
    logic [PTR_BITS-1:0]  grant_idx;
    logic [PTR_BITS-1:0]  cand_idx;
    logic [PTR_BITS-1:0]  ptr_after_grant;

    // Round-robin arbiter: first pending requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found     = 1'b0;
        grant_idx       = '0;
        cand_idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = PTR_BITS'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.miss_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        ptr_after_grant = PTR_BITS'((int'(grant_idx) + 1) % NUM_REQ);
    end

    // State register; reset aborts any fill in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the granted block address, advance the pointer, capture returned data
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            blk_q   <= '0;
            data_q  <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                blk_q   <= bus.miss_addr[grant_idx][ADDR_BITS-1:OFF_BITS];
                grant_q <= grant_idx;
                rr_ptr  <= ptr_after_grant;
            end
            if (state == WAIT && bus.mem_resp_valid) begin
                data_q <= bus.mem_resp_data;
            end
        end
    end

    // Next-state decode and all outputs; outputs are zero outside their state
    always_comb begin
        state_next        = state;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.wr_en         = 1'b0;
        bus.wr_idx        = '0;
        bus.wr_tag        = '0;
        bus.wr_data       = '0;
        bus.fill_done     = '0;
        busy              = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {blk_q, {OFF_BITS{1'b0}}};
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.wr_en   = 1'b1;
                bus.wr_idx  = blk_q[IDX_BITS-1:0];
                bus.wr_tag  = blk_q[BLK_BITS-1 -: TAG_BITS];
                bus.wr_data = data_q;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if ((bus.miss_valid[j] &&
                         bus.miss_addr[j][ADDR_BITS-1:OFF_BITS] == blk_q) ||
                        PTR_BITS'(j) == grant_q) begin
                        bus.fill_done[j] = 1'b1;
                    end
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: expected fills and memory requests
// are queued when misses are driven and compared as the DUT produces them.
module tb_cache_fill_ctrl;
    localparam int NUM_REQ    = 2;
    localparam int NUM_LINES  = 16;
    localparam int BLOCK_SIZE = 8;
    localparam int DATA_BITS  = 64;
    localparam int TAG_BITS   = 25;
    localparam int IDX_BITS   = $clog2(NUM_LINES);
    localparam int OFF_BITS   = $clog2(BLOCK_SIZE);
    localparam int ADDR_BITS  = TAG_BITS + IDX_BITS + OFF_BITS;

    typedef struct {
        logic [IDX_BITS-1:0]  idx;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
        logic [NUM_REQ-1:0]   done;
    } fill_t;

    logic clock;
    logic reset;
    logic busy;

    cache_fill_ctrl_if #(
        .NUM_REQ(NUM_REQ), .NUM_LINES(NUM_LINES), .BLOCK_SIZE(BLOCK_SIZE),
        .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS)
    ) bus ();

    cache_fill_ctrl #(
        .NUM_REQ(NUM_REQ), .NUM_LINES(NUM_LINES), .BLOCK_SIZE(BLOCK_SIZE),
        .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    int check_count = 0;
    int error_count = 0;
    int cycle_count = 0;

    fill_t                exp_q[$];
    logic [ADDR_BITS-1:0] req_q[$];
    logic [NUM_REQ-1:0]   done_seen = '0;

    int wr_en_count       = 0;
    int last_fill_cycle   = 0;
    int handshakes        = 0;
    int valid_cycles      = 0;
    int last_valid_cycles = 0;
    int resp_delay        = 1;
    int stall_left        = 0;
    bit spurious_on_stall = 1'b0;

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used for latency measurement
    initial begin
        forever begin
            @(posedge clock);
            cycle_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory contents seen by the fill controller
    function automatic logic [DATA_BITS-1:0] memData(input logic [ADDR_BITS-1:0] a);
        if (a == 32'h0000_1238) return 64'hDEADBEEF_CAFEF00D;
        return {~a, a};
    endfunction

    function automatic logic [ADDR_BITS-1:0] blockOf(input logic [ADDR_BITS-1:0] a);
        return {a[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    endfunction

    task automatic pushReq(input logic [ADDR_BITS-1:0] a);
        req_q.push_back(blockOf(a));
    endtask

    task automatic pushFill(input logic [ADDR_BITS-1:0] a, input logic [NUM_REQ-1:0] done);
        fill_t f;
        f.idx  = a[OFF_BITS +: IDX_BITS];
        f.tag  = a[ADDR_BITS-1 -: TAG_BITS];
        f.data = memData(blockOf(a));
        f.done = done;
        exp_q.push_back(f);
    endtask

    // Advance to just after the next rising edge; requesters drop after fill_done
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            bus.miss_valid = bus.miss_valid & ~done_seen;
        end
    endtask

    task automatic applyStimulus(input int req, input logic [ADDR_BITS-1:0] a);
        bus.miss_addr[req]  = a;
        bus.miss_valid[req] = 1'b1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            waitCycles(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        waitCycles(2);
        checkOutput("busy_after_drain", busy, 0);
    endtask

    task automatic doReset();
        reset          = 1'b1;
        bus.miss_valid = '0;
        waitCycles(2);
        reset = 1'b0;
    endtask

    // Memory model: accepts requests, returns blocks after resp_delay cycles
    initial begin : memory_model
        logic                 accepted;
        logic                 in_wait;
        logic                 rst_at_edge;
        int                   wait_left;
        logic [ADDR_BITS-1:0] addr_seen;
        logic [ADDR_BITS-1:0] pend_addr;
        accepted  = 1'b0;
        in_wait   = 1'b0;
        wait_left = 0;
        addr_seen = '0;
        pend_addr = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clock);
            rst_at_edge = reset;
            #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
            if (rst_at_edge) begin
                accepted     = 1'b0;
                in_wait      = 1'b0;
                valid_cycles = 0;
            end else begin
                if (accepted) begin
                    handshakes++;
                    last_valid_cycles = valid_cycles;
                    valid_cycles      = 0;
                    in_wait           = 1'b1;
                    wait_left         = resp_delay;
                    pend_addr         = addr_seen;
                    if (req_q.size() > 0) void'(req_q.pop_front());
                end
                accepted = 1'b0;
                if (in_wait) begin
                    if (wait_left == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = memData(pend_addr);
                        in_wait            = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end
                if (bus.mem_req_valid) begin
                    valid_cycles++;
                    if (req_q.size() == 0) checkOutput("unexpected_req", req_q.size(), 1);
                    else checkOutput("req_addr", bus.mem_req_addr, req_q[0]);
                    if (stall_left > 0) begin
                        stall_left--;
                        if (spurious_on_stall) begin
                            bus.mem_resp_valid = 1'b1;
                            bus.mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
                        end
                    end else begin
                        bus.mem_req_ready = 1'b1;
                        accepted          = 1'b1;
                        addr_seen         = bus.mem_req_addr;
                    end
                end
            end
        end
    end

    // Monitor: every cachemem write is popped against the scoreboard
    initial begin : monitor
        fill_t e;
        forever begin
            @(negedge clock);
            if (bus.wr_en) begin
                wr_en_count++;
                last_fill_cycle = cycle_count;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wr_en", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_idx", bus.wr_idx, e.idx);
                    checkOutput("wr_tag", bus.wr_tag, e.tag);
                    checkOutput("wr_data", bus.wr_data, e.data);
                    checkOutput("fill_done", bus.fill_done, e.done);
                end
            end else if (bus.fill_done != '0) begin
                checkOutput("stray_fill_done", bus.fill_done, 0);
            end
            done_seen = bus.fill_done;
        end
    end

    // Safety net in case the design wedges the whole run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int hs0;
        int miss_cycle;
        int wr_before;
        int n;
        reset          = 1'b1;
        bus.miss_valid = '0;
        bus.miss_addr  = '0;
        waitCycles(3);
        reset = 1'b0;

        $display("[TB] reset and idle");
        repeat (10) begin
            @(negedge clock);
            checkOutput("idle_ctrl", {bus.mem_req_valid, bus.wr_en, bus.fill_done, busy}, 0);
            checkOutput("idle_bus", |{bus.mem_req_addr, bus.wr_idx, bus.wr_tag, bus.wr_data}, 0);
        end
        waitCycles(1);

        $display("[TB] single miss on requester 0");
        resp_delay = 1;
        pushReq(32'h0000_1238);
        pushFill(32'h0000_1238, 2'b01);
        applyStimulus(0, 32'h0000_1238);
        waitDrain(50);

        $display("[TB] two misses to different blocks");
        doReset();
        checkOutput("rr_ptr_reset", dut.rr_ptr, 0);
        pushReq(32'h0000_0100);
        pushReq(32'h0000_0208);
        pushFill(32'h0000_0100, 2'b01);
        pushFill(32'h0000_0208, 2'b10);
        applyStimulus(0, 32'h0000_0100);
        applyStimulus(1, 32'h0000_0208);
        waitDrain(80);
        checkOutput("rr_ptr_end", dut.rr_ptr, 0);

        $display("[TB] two misses to the same block");
        resp_delay = 0;
        hs0 = handshakes;
        pushReq(32'h0000_0340);
        pushFill(32'h0000_0340, 2'b11);
        miss_cycle = cycle_count;
        applyStimulus(0, 32'h0000_0340);
        applyStimulus(1, 32'h0000_0344);
        waitDrain(50);
        checkOutput("one_request", handshakes - hs0, 1);
        checkOutput("min_latency", last_fill_cycle - miss_cycle, 3);

        $display("[TB] backpressure with spurious response");
        resp_delay        = 1;
        stall_left        = 5;
        spurious_on_stall = 1'b1;
        hs0 = handshakes;
        pushReq(32'h0000_1000);
        pushFill(32'h0000_1000, 2'b10);
        applyStimulus(1, 32'h0000_1000);
        waitDrain(60);
        spurious_on_stall = 1'b0;
        checkOutput("req_valid_cycles", last_valid_cycles, 6);
        checkOutput("bp_one_request", handshakes - hs0, 1);

        $display("[TB] reset during WAIT");
        resp_delay = 20;
        hs0 = handshakes;
        pushReq(32'h0000_2000);
        applyStimulus(0, 32'h0000_2000);
        n = 0;
        while (handshakes == hs0 && n < 20) begin
            waitCycles(1);
            n++;
        end
        checkOutput("abort_handshake", handshakes - hs0, 1);
        waitCycles(1);
        checkOutput("busy_in_wait", busy, 1);
        wr_before      = wr_en_count;
        reset          = 1'b1;
        bus.miss_valid = '0;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("busy_after_reset", busy, 0);
        checkOutput("rr_ptr_after_reset", dut.rr_ptr, 0);
        waitCycles(25);
        checkOutput("no_write_after_abort", wr_en_count - wr_before, 0);
        checkOutput("idle_after_abort", busy, 0);

        $display("[TB] fresh misses after reset");
        resp_delay = 1;
        pushReq(32'h0000_3000);
        pushReq(32'h0000_4000);
        pushFill(32'h0000_3000, 2'b01);
        pushFill(32'h0000_4000, 2'b10);
        applyStimulus(0, 32'h0000_3000);
        applyStimulus(1, 32'h0000_4000);
        waitDrain(80);
        checkOutput("req_queue_empty", req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
